// File: rtl/lab2_pkg.sv
// Shared Lab2 definitions: BIST controller states, vector count and the
// reference full-subtractor equation used by synthesizable checkers.
package lab2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } bist_state_t;

    localparam int NUM_VEC = 8;

    // Golden full subtractor x - y - z, returned as {borrow, difference}.
    function automatic logic [1:0] sub_golden(input logic x, input logic y, input logic z);
        logic b;
        logic d;
        d = x ^ y ^ z;
        b = (~x & y) | (~x & z) | (y & z);
        return {b, d};
    endfunction

endpackage

// File: rtl/lab2_sub_golden.sv
// Combinational reference full subtractor; kept as its own module so other
// Lab2 checkers can reuse the same golden response.
module lab2_sub_golden
    import lab2_pkg::*;
(
    input  logic x_i,
    input  logic y_i,
    input  logic z_i,
    output logic b_o,
    output logic d_o
);

    assign {b_o, d_o} = sub_golden(x_i, y_i, z_i);

endmodule

// File: rtl/lab2_sub_bist.sv
// Built-in self test for the Lab2 full subtractor. Walks {x,y,z} through
// 000..111, waits SETTLE_CYCLES per vector, compares the DUT's borrow and
// difference against the golden model and counts mismatches (saturating).
// Optional first-failure capture: define LAB2_SUB_BIST_FAIL_CAPTURE_EN to
// add the fail_vec port and its register.
module lab2_sub_bist
    import lab2_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,   // legal 1..15
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dut_b,
    input  logic             dut_d,
    output logic             x,
    output logic             y,
    output logic             z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt
`ifdef LAB2_SUB_BIST_FAIL_CAPTURE_EN
    ,
    output logic [2:0]       fail_vec
`endif
);

    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [2:0]       VEC_LAST = 3'(NUM_VEC - 1);

    bist_state_t      state_q, state_d;
    logic [2:0]       vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
`ifdef LAB2_SUB_BIST_FAIL_CAPTURE_EN
    logic [2:0]       fail_q, fail_d;
`endif

    logic gold_b;
    logic gold_d;
    logic mismatch;

    // The stimulus register doubles as the vector index, so the golden
    // model sees exactly what the DUT sees.
    lab2_sub_golden u_golden (
        .x_i (vec_q[2]),
        .y_i (vec_q[1]),
        .z_i (vec_q[0]),
        .b_o (gold_b),
        .d_o (gold_d)
    );

    // Either wrong bit counts as a single error for this vector.
    assign mismatch = (dut_b != gold_b) || (dut_d != gold_d);

    // State and datapath registers; reset returns everything to idle/zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
`ifdef LAB2_SUB_BIST_FAIL_CAPTURE_EN
            fail_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef LAB2_SUB_BIST_FAIL_CAPTURE_EN
            fail_q  <= fail_d;
`endif
        end
    end

    // Next-state logic: settle each vector, check it once, then advance.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
`ifdef LAB2_SUB_BIST_FAIL_CAPTURE_EN
        fail_d  = fail_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                // A new run is only accepted when not busy.
                if (start) begin
                    state_d = WAIT;
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
`ifdef LAB2_SUB_BIST_FAIL_CAPTURE_EN
                    fail_d  = '0;
`endif
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
`ifdef LAB2_SUB_BIST_FAIL_CAPTURE_EN
                    // Count is still zero only on the first mismatch of the run.
                    if (err_q == '0) begin
                        fail_d = vec_q;
                    end
`endif
                end
                if (vec_q == VEC_LAST) begin
                    // vec stays at 111, which is what DONE drives.
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign {x, y, z} = vec_q;
    assign busy      = (state_q == WAIT) || (state_q == CHECK);
    assign done      = (state_q == DONE);
    assign pass      = (state_q == DONE) && (err_q == '0);
    assign err_cnt   = err_q;
`ifdef LAB2_SUB_BIST_FAIL_CAPTURE_EN
    assign fail_vec  = fail_q;
`endif

endmodule

// File: tb/tb_lab2_sub_bist.sv
// Bench for lab2_sub_bist. A behavioural subtractor with per-vector fault
// masks stands in for the Lab2 DUT; expected counts come from x-y-z arithmetic.
module tb_lab2_sub_bist;

    localparam int S0   = 2;
    localparam int S1   = 1;
    localparam int CYC0 = S0 + 1;
    localparam int CYC1 = S1 + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    logic x0, y0, z0, busy0, done0, pass0, dut_b0, dut_d0;
    logic [3:0] err0;
    logic x1, y1, z1, busy1, done1, pass1, dut_b1, dut_d1;
    logic [1:0] err1;
`ifdef LAB2_SUB_BIST_FAIL_CAPTURE_EN
    logic [2:0] fv0, fv1;
`endif

    logic [7:0] fault_d = 8'h00;
    logic [7:0] fault_b = 8'h00;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Reference: difference and borrow straight from integer x - y - z.
    function automatic logic [1:0] model_bd(input int v);
        int xi, yi, zi, diff;
        xi   = (v >> 2) & 1;
        yi   = (v >> 1) & 1;
        zi   = v & 1;
        diff = xi - yi - zi;
        return {(diff < 0), ((diff & 1) != 0)};
    endfunction

    function automatic bit vec_bad(input int v);
        return (fault_b[v] | fault_d[v]) == 1'b1;
    endfunction

    // Simulated Lab2 DUTs with injected faults.
    logic [2:0] v0, v1;
    logic [1:0] g0, g1;
    always_comb begin
        v0 = {x0, y0, z0};
        g0 = model_bd(int'(v0));
        dut_b0 = g0[1] ^ fault_b[v0];
        dut_d0 = g0[0] ^ fault_d[v0];
        v1 = {x1, y1, z1};
        g1 = model_bd(int'(v1));
        dut_b1 = g1[1] ^ fault_b[v1];
        dut_d1 = g1[0] ^ fault_d[v1];
    end

    lab2_sub_bist #(.SETTLE_CYCLES(S0), .ERR_W(4)) u0 (
        .clk(clk), .rst(rst), .start(start0), .dut_b(dut_b0), .dut_d(dut_d0),
        .x(x0), .y(y0), .z(z0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0)
`ifdef LAB2_SUB_BIST_FAIL_CAPTURE_EN
        , .fail_vec(fv0)
`endif
    );

    lab2_sub_bist #(.SETTLE_CYCLES(S1), .ERR_W(2)) u1 (
        .clk(clk), .rst(rst), .start(start1), .dut_b(dut_b1), .dut_d(dut_d1),
        .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1)
`ifdef LAB2_SUB_BIST_FAIL_CAPTURE_EN
        , .fail_vec(fv1)
`endif
    );

    // Full run on u0, checking stimulus, status and running error count each cycle.
    task automatic run_u0(input string name, input int pulse_at);
        int exp_err[9];
        int first;
        exp_err[0] = 0;
        first = -1;
        for (int v = 0; v < 8; v++) begin
            exp_err[v+1] = exp_err[v];
            if (vec_bad(v)) begin
                if (exp_err[v+1] < 15) exp_err[v+1]++;
                if (first < 0) first = v;
            end
        end
        if (first < 0) first = 0;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        for (int k = 0; k < 8*CYC0; k++) begin
            total++;
            if ({x0, y0, z0} !== 3'(k / CYC0)) begin
                bad++;
                $display("FAIL %s stim k=%0d got=%b want=%b", name, k, {x0, y0, z0}, 3'(k / CYC0));
            end
            total++;
            if ({busy0, done0} !== 2'b10) begin
                bad++;
                $display("FAIL %s busy/done k=%0d got=%b want=10", name, k, {busy0, done0});
            end
            total++;
            if (err0 !== 4'(exp_err[k / CYC0])) begin
                bad++;
                $display("FAIL %s run_err k=%0d got=%0d want=%0d", name, k, err0, exp_err[k / CYC0]);
            end
            if (k == pulse_at) start0 = 1'b1;
            @(negedge clk);
            start0 = 1'b0;
        end
        total++;
        if ({busy0, done0, x0, y0, z0} !== 5'b01111) begin
            bad++;
            $display("FAIL %s end_status got=%b want=01111", name, {busy0, done0, x0, y0, z0});
        end
        total++;
        if (err0 !== 4'(exp_err[8])) begin
            bad++;
            $display("FAIL %s err_cnt got=%0d want=%0d", name, err0, exp_err[8]);
        end
        total++;
        if (pass0 !== (exp_err[8] == 0)) begin
            bad++;
            $display("FAIL %s pass got=%b want=%b", name, pass0, (exp_err[8] == 0));
        end
`ifdef LAB2_SUB_BIST_FAIL_CAPTURE_EN
        total++;
        if (fv0 !== 3'(first)) begin
            bad++;
            $display("FAIL %s fail_vec got=%b want=%b", name, fv0, 3'(first));
        end
`endif
        $display("run %s: fault_d=%h fault_b=%h err_cnt=%0d pass=%b", name, fault_d, fault_b, err0, pass0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++;
        if ({x0, y0, z0, busy0, done0, pass0, err0} !== 10'b0) begin
            bad++;
            $display("FAIL reset_u0 got=%b want=0", {x0, y0, z0, busy0, done0, pass0, err0});
        end
`ifdef LAB2_SUB_BIST_FAIL_CAPTURE_EN
        total++;
        if (fv0 !== 3'b000) begin
            bad++;
            $display("FAIL reset_fail_vec got=%b want=000", fv0);
        end
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({busy0, done0, err0} !== 6'b0) begin
            bad++;
            $display("FAIL idle_hold got=%b want=0", {busy0, done0, err0});
        end
        $display("reset: outputs zero, idle");
    endtask

    task automatic test_clean();
        fault_d = 8'h00; fault_b = 8'h00;
        run_u0("clean", -1);
    endtask

    task automatic test_d_inverted();
        fault_d = 8'hFF; fault_b = 8'h00;
        run_u0("d_inverted", -1);
    endtask

    task automatic test_b_stuck0();
        fault_d = 8'h00;
        for (int v = 0; v < 8; v++) fault_b[v] = model_bd(v)[1];
        run_u0("b_stuck0", -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 5; i++) begin
            fault_d = 8'($urandom) & 8'($urandom);
            fault_b = 8'($urandom) & 8'($urandom);
            run_u0("random", -1);
        end
    endtask

    task automatic test_start_in_wait();
        fault_d = 8'h24; fault_b = 8'h00;
        run_u0("start_in_wait", 4);
    endtask

    task automatic test_restart_from_done();
        fault_d = 8'hFF; fault_b = 8'h00;
        run_u0("fail_before_restart", -1);
        fault_d = 8'h00;
        run_u0("restart_from_done", -1);
    endtask

    task automatic test_mid_reset();
        fault_d = 8'hFF; fault_b = 8'h00;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        repeat (3*CYC0) @(negedge clk);
        total++;
        if ({x0, y0, z0} !== 3'b011 || err0 !== 4'd3) begin
            bad++;
            $display("FAIL pre_reset got=%b/%0d want=011/3", {x0, y0, z0}, err0);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({x0, y0, z0, busy0, done0, pass0, err0} !== 10'b0) begin
            bad++;
            $display("FAIL async_reset got=%b want=0", {x0, y0, z0, busy0, done0, pass0, err0});
        end
        @(negedge clk) rst = 1'b0;
        $display("mid_reset: cleared at vec 011");
        fault_d = 8'h00;
        run_u0("after_mid_reset", -1);
    endtask

    // ERR_W=2, SETTLE_CYCLES=1 instance: count must stick at 3.
    task automatic test_saturation(input logic [7:0] fd);
        int n;
        fault_d = fd; fault_b = 8'h00;
        n = 0;
        for (int v = 0; v < 8; v++) if (vec_bad(v) && n < 3) n++;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        for (int k = 0; k < 8*CYC1; k++) begin
            total++;
            if ({busy1, done1, x1, y1, z1} !== {2'b10, 3'(k / CYC1)}) begin
                bad++;
                $display("FAIL sat_run k=%0d got=%b want=%b", k, {busy1, done1, x1, y1, z1}, {2'b10, 3'(k / CYC1)});
            end
            @(negedge clk);
        end
        total++;
        if ({done1, pass1, err1} !== {1'b1, (n == 0), 2'(n)}) begin
            bad++;
            $display("FAIL sat_end got=%b want=%b", {done1, pass1, err1}, {1'b1, (n == 0), 2'(n)});
        end
        $display("run saturation: fault_d=%h err_cnt=%0d pass=%b", fd, err1, pass1);
    endtask

    initial begin
        test_reset();
        test_clean();
        test_d_inverted();
        test_b_stuck0();
        test_random();
        test_start_in_wait();
        test_restart_from_done();
        test_mid_reset();
        test_saturation(8'hFF);
        test_saturation(8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
